// File: rtl/mdu.sv
// mdu -- multiply/divide unit for the E stage of the pipelined MIPS core.
//
// Runs mult/multu/div/divu as multi-cycle operations into architectural
// HI/LO, services mthi/mtlo writes, and provides the mfhi/mflo read value
// on rdata. The result is computed when the operation is accepted and
// parked in shadow registers {shi, slo}. It is committed to {hi, lo} on the
// same edge at which busy falls.
//
// Optional feature: define MDU_MADD_EN to implement op 7 (madd):
//   {hi, lo} <= {hi, lo} + signed(a) * signed(b)
// Without the macro, op 7 is a no-op like any other undefined op.
//
// Request handshake: start is a one-cycle request. op, a and b are sampled
// on the edge where start is high and the FSM is IDLE. While busy is high,
// start is ignored regardless of op. There is no backpressure beyond busy.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        rd_hi,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] shi;
  logic [31:0] slo;
  // Cleared for divide-by-zero so HI/LO survive the operation untouched.
  logic        upd;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        div_signed;
  logic [31:0] dvd_mag;
  logic [31:0] dvs_mag;
  logic [31:0] quo_mag;
  logic [31:0] rem_mag;
  logic [31:0] quo;
  logic [31:0] rem;

  // Multiply: a 64x64 product of the sign- or zero-extended operands,
  // truncated to 64 bits, is the exact 32x32 product in both cases.
  always_comb begin
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u = {32'd0, a} * {32'd0, b};
  end

  // Divide via magnitudes: the quotient truncates toward zero, and the
  // remainder follows the sign of the dividend. 0x80000000 / -1 gives
  // magnitude 0x80000000. Negating it wraps back to 0x80000000 with
  // remainder 0.
  always_comb begin
    div_signed = (op == OP_DIV);
    dvd_mag    = (div_signed && a[31]) ? (32'd0 - a) : a;
    dvs_mag    = (div_signed && b[31]) ? (32'd0 - b) : b;
    quo_mag    = 32'd0;
    rem_mag    = 32'd0;
    if (dvs_mag != 32'd0) begin
      quo_mag = dvd_mag / dvs_mag;
      rem_mag = dvd_mag % dvs_mag;
    end
    quo = (div_signed && (a[31] ^ b[31])) ? (32'd0 - quo_mag) : quo_mag;
    rem = (div_signed && a[31]) ? (32'd0 - rem_mag) : rem_mag;
  end

  // mfhi/mflo read path: zero latency from rd_hi and the HI/LO registers.
  always_comb begin
    rdata = rd_hi ? hi : lo;
  end

  // Control FSM, counter, shadow result and architectural HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      busy  <= 1'b0;
      upd   <= 1'b0;
      shi   <= 32'd0;
      slo   <= 32'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT: begin
                {shi, slo} <= prod_s;
                upd        <= 1'b1;
                cnt        <= MULT_N;
                busy       <= 1'b1;
                state      <= RUN;
              end
              OP_MULTU: begin
                {shi, slo} <= prod_u;
                upd        <= 1'b1;
                cnt        <= MULT_N;
                busy       <= 1'b1;
                state      <= RUN;
              end
              OP_DIV, OP_DIVU: begin
                shi   <= rem;
                slo   <= quo;
                upd   <= (b != 32'd0);
                cnt   <= DIV_N;
                busy  <= 1'b1;
                state <= RUN;
              end
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
`ifdef MDU_MADD_EN
              OP_MADD: begin
                {shi, slo} <= {hi, lo} + prod_s;
                upd        <= 1'b1;
                cnt        <= MULT_N;
                busy       <= 1'b1;
                state      <= RUN;
              end
`endif
              default: ;
            endcase
          end
        end
        RUN: begin
          // Any start seen here is dropped; the hazard unit never sends one.
          if (cnt == 4'd1) begin
            if (upd) begin
              hi <= shi;
              lo <= slo;
            end
            cnt   <= 4'd0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

endmodule
